axis_route_switch: RTL

// - Per-input route stage of the mesh router: accepts one AXI-Stream input and steers whole packets to one of CHANNEL_NUMBER outputs.
// - Route is decoded from the header flit (XY or YX order) and locked until TLAST; malformed or out-of-mesh packets are dropped and counted.
// - Registered 2-entry skid buffer on the output gives 1-cycle latency at full throughput.

---
 rtl/axis_route_switch.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/axis_route_switch.sv
// axis_route_switch: per-input route stage of the mesh router.
// Decodes the target from the header flit (XY or YX order), locks the route
// until TLAST and steers the whole packet into a 2-entry registered skid buffer
// that drives exactly one output channel. Malformed or out-of-mesh packets are
// consumed without output and counted in a saturating drop counter.
module axis_route_switch #(
    parameter int unsigned         DATA_WIDTH     = 32,
    parameter int unsigned         ID_WIDTH       = 4,
    parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '1,
    parameter int unsigned         CHANNEL_NUMBER = 5,
    parameter int unsigned         MAX_ROUTERS_X  = 4,
    parameter int unsigned         MAX_ROUTERS_Y  = 4,
    parameter int unsigned         ROUTER_X       = 0,
    parameter int unsigned         ROUTER_Y       = 0,
    parameter int unsigned         ROUTING_MODE   = 0
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [DATA_WIDTH-1:0]                    in_tdata_i,
    input  logic [ID_WIDTH-1:0]                      in_tid_i,
    input  logic                                     in_tlast_i,
    input  logic                                     in_tvalid_i,
    output logic                                     in_tready_o,
    output logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0] out_tdata_o,
    output logic [CHANNEL_NUMBER-1:0][ID_WIDTH-1:0]   out_tid_o,
    output logic [CHANNEL_NUMBER-1:0]                 out_tlast_o,
    output logic [CHANNEL_NUMBER-1:0]                 out_tvalid_o,
    input  logic [CHANNEL_NUMBER-1:0]                 out_tready_i,
    output logic                                     busy_o,
    output logic [15:0]                              drop_cnt_o
);

    localparam int unsigned XW = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
    localparam int unsigned YW = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;
    localparam int unsigned CW = $clog2(CHANNEL_NUMBER);

    localparam logic [CW-1:0] CH_LOCAL = CW'(0);
    localparam logic [CW-1:0] CH_NORTH = CW'(1);
    localparam logic [CW-1:0] CH_EAST  = CW'(2);
    localparam logic [CW-1:0] CH_SOUTH = CW'(3);
    localparam logic [CW-1:0] CH_WEST  = CW'(4);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   tid;
        logic                  last;
        logic [CW-1:0]         ch;
    } entry_t;

    state_t        state;
    logic [CW-1:0] route_q;
    logic [15:0]   drop_cnt;
    entry_t        head;
    entry_t        tail;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          ready;

    logic [31:0]   tx;
    logic [31:0]   ty;
    logic          legal;
    logic [CW-1:0] x_ch;
    logic [CW-1:0] y_ch;
    logic [CW-1:0] route_dec;

    logic          accept;
    logic          is_hdr;
    logic          push;
    logic          pop;
    logic [CW-1:0] push_ch;
    logic          drop_done;
    entry_t        incoming;

    // Decode the target channel and mesh legality from the current input flit
    always_comb begin
        tx        = 32'(in_tdata_i[XW-1:0]);
        ty        = 32'(in_tdata_i[XW+YW-1:XW]);
        legal     = (tx < MAX_ROUTERS_X) && (ty < MAX_ROUTERS_Y);
        x_ch      = (tx > ROUTER_X) ? CH_EAST : CH_WEST;
        y_ch      = (ty > ROUTER_Y) ? CH_NORTH : CH_SOUTH;
        route_dec = CH_LOCAL;
        if (ROUTING_MODE == 0) begin
            if (tx != ROUTER_X) begin
                route_dec = x_ch;
            end else if (ty != ROUTER_Y) begin
                route_dec = y_ch;
            end
        end else begin
            if (ty != ROUTER_Y) begin
                route_dec = y_ch;
            end else if (tx != ROUTER_X) begin
                route_dec = x_ch;
            end
        end
    end

    // Handshake, push/pop and drop-completion decisions for this cycle
    always_comb begin
        accept    = in_tvalid_i & ready;
        is_hdr    = (in_tid_i == ROUTING_HEADER);
        push      = 1'b0;
        push_ch   = route_q;
        drop_done = 1'b0;
        case (state)
            IDLE: begin
                if (is_hdr && legal) begin
                    push    = accept;
                    push_ch = route_dec;
                end else begin
                    drop_done = accept & in_tlast_i;
                end
            end
            FWD: begin
                push = accept;
            end
            DROP: begin
                drop_done = accept & in_tlast_i;
            end
            default: begin
                push = 1'b0;
            end
        endcase
        pop           = (count != 2'd0) && out_tready_i[head.ch];
        incoming.data = in_tdata_i;
        incoming.tid  = in_tid_i;
        incoming.last = in_tlast_i;
        incoming.ch   = push_ch;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Packet FSM: route lock, drop tracking and saturating drop counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            route_q  <= CH_LOCAL;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (is_hdr && !in_tlast_i) begin
                            if (legal) begin
                                state   <= FWD;
                                route_q <= route_dec;
                            end else begin
                                state <= DROP;
                            end
                        end
                    end
                    FWD, DROP: begin
                        if (in_tlast_i) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (drop_done && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Skid buffer storage; input ready is registered from the next fill level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= 2'd0;
            ready <= 1'b1;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count_next;
            ready <= (count_next != 2'd2);
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= incoming;
                    end else begin
                        tail <= incoming;
                    end
                end
                2'b01: begin
                    head <= tail;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new flit lands behind whatever remains
                    if (count == 2'd1) begin
                        head <= incoming;
                    end else begin
                        head <= tail;
                        tail <= incoming;
                    end
                end
                default: begin
                    head <= head;
                end
            endcase
        end
    end

    // Head entry is broadcast on every channel but only its channel sees valid
    always_comb begin
        for (int unsigned c = 0; c < CHANNEL_NUMBER; c++) begin
            out_tdata_o[c]  = head.data;
            out_tid_o[c]    = head.tid;
            out_tlast_o[c]  = head.last;
            out_tvalid_o[c] = (count != 2'd0) && (head.ch == CW'(c));
        end
    end

    assign in_tready_o = ready;
    assign busy_o      = (state != IDLE);
    assign drop_cnt_o  = drop_cnt;

endmodule
